// File: rtl/rca_nibble_seq_if.sv
// Handshake and adder-side bundle for the nibble-serial adder sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface rca_nibble_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic [3:0]       add_a;
  logic [3:0]       add_b;
  logic             add_cin;
  logic [3:0]       add_sum;
  logic             add_cout;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready, add_sum, add_cout,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, add_a, add_b, add_cin
  );
endinterface

// File: rtl/rca_nibble_seq.sv
// Nibble-serial sequencer around an external 4-bit ripple-carry adder:
// one nibble per cycle, LSB first, carry chained through a register.
module rca_nibble_seq #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  rca_nibble_seq_if.slave    bus
);
  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  generate
    if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("rca_nibble_seq: WIDTH must be a multiple of 4 and >= 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q,   state_d;
  logic [IDXW-1:0]  idx_q,     idx_d;
  logic             carry_q,   carry_d;
  logic [WIDTH-1:0] a_q,       a_d;
  logic [WIDTH-1:0] b_q,       b_d;
  logic             cin_q,     cin_d;
  logic [WIDTH-1:0] result_q,  result_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic             out_cout_q, out_cout_d;
  logic             out_ovf_q,  out_ovf_d;

  logic [3:0] a_nib [NIB];
  logic [3:0] b_nib [NIB];

  generate
    for (genvar gi = 0; gi < NIB; gi++) begin : g_nib
      assign a_nib[gi] = a_q[4*gi +: 4];
      assign b_nib[gi] = b_q[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      carry_q    <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      result_q   <= '0;
      out_sum_q  <= '0;
      out_cout_q <= 1'b0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      carry_q    <= carry_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      result_q   <= result_d;
      out_sum_q  <= out_sum_d;
      out_cout_q <= out_cout_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    result_d   = result_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
    out_ovf_d  = out_ovf_q;

    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.add_a     = 4'd0;
    bus.add_b     = 4'd0;
    bus.add_cin   = 1'b0;

    case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          a_d      = bus.in_a;
          b_d      = bus.in_b;
          cin_d    = bus.in_cin;
          idx_d    = '0;
          carry_d  = 1'b0;
          result_d = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        bus.add_a   = a_nib[idx_q];
        bus.add_b   = b_nib[idx_q];
        bus.add_cin = (idx_q == '0) ? cin_q : carry_q;
        for (int i = 0; i < NIB; i++) begin
          if (idx_q == IDXW'(i)) result_d[4*i +: 4] = bus.add_sum;
        end
        carry_d = bus.add_cout;
        // The final nibble's sum and carry go straight into the output
        // registers so the result is presented on the first DONE cycle.
        if (idx_q == IDXW'(NIB - 1)) begin
          state_d    = S_DONE;
          out_sum_d  = result_d;
          out_cout_d = bus.add_cout;
          out_ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                       (result_d[WIDTH-1] != a_q[WIDTH-1]);
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end
      S_DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.out_sum  = out_sum_q;
  assign bus.out_cout = out_cout_q;
  assign bus.out_ovf  = out_ovf_q;
endmodule

// File: tb/tb_rca_nibble_seq.sv
// Self-checking bench for rca_nibble_seq: directed corner cases plus random
// transactions, with a behavioural adder and an arithmetic reference model.
module tb_rca_nibble_seq;
  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  rca_nibble_seq_if #(.WIDTH(WIDTH)) bus ();

  rca_nibble_seq #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External combinational 4-bit adder.
  assign {bus.add_cout, bus.add_sum} = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {4'd0, bus.add_cin};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Carry into nibble k is bit 4k of the sum of the low 4k bits plus cin.
  function automatic logic nib_carry_in(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin, input int k);
    longint unsigned mask, s;
    mask = (64'd1 << (4 * k)) - 64'd1;
    s = (longint'(a) & mask) + (longint'(b) & mask) + longint'(cin);
    return s[4*k];
  endfunction

  task automatic run_txn(input logic [15:0] a, input logic [15:0] b, input logic cin,
                         input int hold);
    logic [16:0] full;
    logic [15:0] exp_sum;
    logic        exp_cout, exp_ovf;
    int          w, j;
    full     = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    exp_sum  = full[15:0];
    exp_cout = full[16];
    exp_ovf  = (a[15] == b[15]) && (full[15] != a[15]);

    w = 0;
    while (!bus.in_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check_eq("in_ready_before_accept", {31'd0, bus.in_ready}, 32'd1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    @(posedge clk);

    j = 0;
    while (j < 20) begin
      @(negedge clk);
      if (j == 0) begin
        bus.in_valid = 1'b0;
        bus.in_a     = 16'($urandom);
        bus.in_b     = 16'($urandom);
        bus.in_cin   = 1'($urandom);
      end
      if (bus.out_valid) break;
      if (j < NIB) begin
        check_eq("run_add_a",   {28'd0, bus.add_a},   {28'd0, a[4*j +: 4]});
        check_eq("run_add_b",   {28'd0, bus.add_b},   {28'd0, b[4*j +: 4]});
        check_eq("run_add_cin", {31'd0, bus.add_cin}, {31'd0, nib_carry_in(a, b, cin, j)});
      end
      j++;
    end
    check_eq("latency", j, NIB);

    for (int h = 0; h <= hold; h++) begin
      check_eq("done_valid", {31'd0, bus.out_valid}, 32'd1);
      check_eq("done_sum",   {16'd0, bus.out_sum},   {16'd0, exp_sum});
      check_eq("done_cout",  {31'd0, bus.out_cout},  {31'd0, exp_cout});
      check_eq("done_ovf",   {31'd0, bus.out_ovf},   {31'd0, exp_ovf});
      check_eq("done_ready", {31'd0, bus.in_ready},  32'd0);
      check_eq("done_add_a", {28'd0, bus.add_a},     32'd0);
      if (h < hold) begin
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 16'($urandom);
        bus.in_b      = 16'($urandom);
        @(negedge clk);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check_eq("post_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("post_ready", {31'd0, bus.in_ready},  32'd1);
    $display("txn a=%04h b=%04h cin=%0d -> sum=%04h cout=%0d ovf=%0d (exp %04h %0d %0d)",
             a, b, cin, bus.out_sum, bus.out_cout, bus.out_ovf, exp_sum, exp_cout, exp_ovf);
  endtask

  task automatic reset_mid_run(input logic [15:0] a, input logic [15:0] b);
    logic seen_valid;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check_eq("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_out_sum",   {16'd0, bus.out_sum},   32'd0);
    check_eq("rst_out_cout",  {31'd0, bus.out_cout},  32'd0);
    check_eq("rst_out_ovf",   {31'd0, bus.out_ovf},   32'd0);
    check_eq("rst_add_a",     {28'd0, bus.add_a},     32'd0);
    check_eq("rst_add_b",     {28'd0, bus.add_b},     32'd0);
    check_eq("rst_add_cin",   {31'd0, bus.add_cin},   32'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen_valid |= bus.out_valid;
    end
    check_eq("no_valid_after_rst", {31'd0, seen_valid}, 32'd0);
    $display("txn reset mid-run a=%04h b=%04h abandoned", a, b);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check_eq("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("reset_out_sum",   {16'd0, bus.out_sum},   32'd0);
    check_eq("reset_out_cout",  {31'd0, bus.out_cout},  32'd0);
    check_eq("reset_out_ovf",   {31'd0, bus.out_ovf},   32'd0);
    check_eq("reset_add_a",     {28'd0, bus.add_a},     32'd0);
    check_eq("reset_add_cin",   {31'd0, bus.add_cin},   32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_txn(16'h1234, 16'h0FFF, 1'b0, 0);
    run_txn(16'hFFFF, 16'h0001, 1'b0, 0);
    run_txn(16'h7FFF, 16'h0001, 1'b0, 0);
    run_txn(16'h8000, 16'h8000, 1'b0, 0);
    run_txn(16'h0000, 16'h0000, 1'b1, 0);
    run_txn(16'hA5A5, 16'h1111, 1'b1, 5);
    run_txn(16'h0F0F, 16'hF0F0, 1'b1, 0);
    reset_mid_run(16'h1234, 16'h4321);
    run_txn(16'h1234, 16'h4321, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      run_txn(16'($urandom), 16'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
